inst_fetch_queue: RTL and testbench

//  Prefetch buffer between the instruction SRAM and the F/D pipeline register.

---
 rtl/inst_fetch_queue.sv | 102 ++++++++++
 tb/tb_inst_fetch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one sequential SRAM read per cycle
// while a slot can be reserved, and hands {pc, inst} pairs to decode over valid/ready.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_im_req,
  output logic [31:0] o_im_addr,
  input  logic [31:0] i_im_rdata,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_inst,
  output logic [31:0] o_out_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_inst_mem [DEPTH];
  logic [31:0]      r_pc_mem   [DEPTH];

  logic             w_handshake;
  logic             w_pop;
  logic             w_push;
  logic [OCC_W-1:0] w_occ;
  logic             w_im_req;

  assign o_out_valid = (r_count != '0);
  assign o_out_inst  = r_inst_mem[r_rd_ptr];
  assign o_out_pc    = r_pc_mem[r_rd_ptr];
  assign o_im_addr   = r_fetch_pc;
  assign o_im_req    = w_im_req;

  assign w_handshake = o_out_valid && i_out_ready;
  assign w_pop       = w_handshake && !i_redirect;
  assign w_push      = r_inflight && !i_redirect;

  // Reserve a slot for every read in flight so a returning word always has room.
  assign w_occ    = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_handshake);
  assign w_im_req = i_rst_n && !i_redirect && (w_occ < DEPTH_OCC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else begin
      r_inflight <= w_im_req;
      if (w_im_req) begin
        r_req_pc <= r_fetch_pc;
      end
      if (i_redirect) begin
        // Flush: drop queued entries and any returning word, restart at the target.
        r_count    <= '0;
        r_rd_ptr   <= r_wr_ptr;
        r_fetch_pc <= i_redirect_pc;
      end else begin
        if (w_im_req) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_inst_mem[r_wr_ptr] <= i_im_rdata;
          r_pc_mem[r_wr_ptr]   <= r_req_pc;
          r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  a_no_push_when_full: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(w_push && !w_pop && (r_count == DEPTH_CNT))
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table for the listed corner cases, then
// randomized traffic with async reset pulses checked against a queue-based model.
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_im_req     (im_req),
    .o_im_addr    (im_addr),
    .i_im_rdata   (im_rdata),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_inst   (out_inst),
    .o_out_pc     (out_pc)
  );

  always #5 clk = ~clk;

  // SRAM: one-cycle read latency, contents are a fixed function of the address.
  always @(posedge clk) im_rdata <= im_req ? (im_addr ^ KEY) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " im_req"}, 32'(im_req), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_pc"}, out_pc, 32'd0);
    chk({tag, " out_inst"}, out_inst, 32'd0);
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy,
                     input bit req, input logic [31:0] addr, input bit valid,
                     input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    vecs.push_back(v);
  endtask

  // Reference model state: queued PCs, one outstanding read, next fetch address.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_ipc;
  logic [31:0] m_fpc;

  task automatic model_reset();
    mq.delete();
    m_infl = 1'b0;
    m_ipc  = '0;
    m_fpc  = 32'h0;
  endtask

  initial begin
    // Stream from reset with decode always ready.
    add(1, 0, 0, 1, 1, 32'h0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h4, 0, 0);
    add(0, 0, 0, 1, 1, 32'h8, 1, 32'h0);
    add(0, 0, 0, 1, 1, 32'hC, 1, 32'h4);
    add(0, 0, 0, 1, 1, 32'h10, 1, 32'h8);
    // Decode stalled: fetch stops at four buffered entries, then drains in order.
    add(1, 0, 0, 0, 1, 32'h0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h4, 0, 0);
    add(0, 0, 0, 0, 1, 32'h8, 1, 32'h0);
    add(0, 0, 0, 0, 1, 32'hC, 1, 32'h0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 32'h0, 1, 32'h0);
    add(0, 0, 0, 1, 1, 32'h10, 1, 32'h0);
    add(0, 0, 0, 1, 1, 32'h14, 1, 32'h4);
    add(0, 0, 0, 1, 1, 32'h18, 1, 32'h8);
    add(0, 0, 0, 1, 1, 32'h1C, 1, 32'hC);
    add(0, 0, 0, 1, 1, 32'h20, 1, 32'h10);
    // Redirect with 3 queued + 1 inflight, coinciding with a push and a ready pop.
    add(1, 0, 0, 0, 1, 32'h0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h4, 0, 0);
    add(0, 0, 0, 0, 1, 32'h8, 1, 32'h0);
    add(0, 0, 0, 0, 1, 32'hC, 1, 32'h0);
    add(0, 1, 32'h100, 1, 0, 32'h0, 1, 32'h0);
    add(0, 0, 0, 1, 1, 32'h100, 0, 0);
    add(0, 0, 0, 1, 1, 32'h104, 0, 0);
    add(0, 0, 0, 1, 1, 32'h108, 1, 32'h100);
    add(0, 0, 0, 1, 1, 32'h10C, 1, 32'h104);
    // Back-to-back redirects: the second target wins.
    add(1, 0, 0, 1, 1, 32'h0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h4, 0, 0);
    add(0, 1, 32'h200, 1, 0, 32'h0, 1, 32'h0);
    add(0, 1, 32'h300, 1, 0, 32'h0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h300, 0, 0);
    add(0, 0, 0, 1, 1, 32'h304, 0, 0);
    add(0, 0, 0, 1, 1, 32'h308, 1, 32'h300);
    add(0, 0, 0, 1, 1, 32'h30C, 1, 32'h304);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; out_ready = 1'b0;
        #1;
        chk_reset_outputs("vec reset");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      out_ready   = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d im_req", i), 32'(im_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("vec%0d im_addr", i), im_addr, vecs[i].addr);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].pc);
        chk($sformatf("vec%0d out_inst", i), out_inst, vecs[i].pc ^ KEY);
      end
    end

    // Randomized traffic against the model, with occasional async reset pulses.
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    #1;
    chk_reset_outputs("rand reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          e_valid;
      bit          e_pop;
      bit          e_req;
      int          occ;
      if (cyc != 0) @(negedge clk);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("pulse reset");
        #1;
        rst_n = 1'b1;
        model_reset();
      end
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom & 32'h0000_0FFF;
      out_ready   = ($urandom_range(0, 9) < 6);
      #1;
      e_valid = (mq.size() > 0);
      e_pop   = e_valid && out_ready && !redirect;
      occ     = mq.size() + int'(m_infl) - ((e_valid && out_ready) ? 1 : 0);
      e_req   = !redirect && (occ < DEPTH);
      chk("rand im_req", 32'(im_req), 32'(e_req));
      if (e_req) chk("rand im_addr", im_addr, m_fpc);
      chk("rand out_valid", 32'(out_valid), 32'(e_valid));
      if (e_valid) begin
        chk("rand out_pc", out_pc, mq[0]);
        chk("rand out_inst", out_inst, mq[0] ^ KEY);
      end
      if (redirect) begin
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = redirect_pc;
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_ipc);
        if (e_req) begin
          m_infl = 1'b1;
          m_ipc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end else begin
          m_infl = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
